if_fetch_buf: RTL and testbench

Parametrised instruction-fetch stage for the five-stage LoongArch pipeline. It owns the PC and issues one synchronous-SRAM read per cycle. Returned `{inst, pc}` pairs are buffered in a DEPTH-entry FIFO so a decode-stage stall never drops or re-fetches an instruction. A taken branch flushes the FIFO, discards any in-flight read and redirects fetch in the same cycle.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_fetch_fifo.sv | 47 ++++
 rtl/if_fetch_buf.sv | 146 ++++++++++++++
 tb/tb_if_fetch_buf.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    // Widest PC the buffered payload can carry; if_fetch_buf's PC_W must not exceed it.
    localparam int IF_PC_W = 32;

    // Architectural reset vector used as the default first fetch address.
    localparam logic [31:0] IF_RESET_PC = 32'h1c00_0000;

    // Canonical no-op presented on out_inst while nothing is buffered.
    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    // One buffered fetch result.
    typedef struct packed {
        logic                excp;
        logic [31:0]         inst;
        logic [IF_PC_W-1:0]  pc;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetch entries with a synchronous flush.
// Pointers carry a wrap bit so the count is a plain subtraction.
import if_pkg::*;

module if_fetch_fifo #(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  if_entry_t   wdata,
    output if_entry_t   rdata,
    output logic [AW:0] count
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    if_entry_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Storage write.
    // NOTE: the storage array has no reset; count qualifies every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; reset and flush both empty the FIFO.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage: owns the PC, issues one SRAM read per cycle under
// credit control and buffers {inst, pc} pairs so decode stalls never drop or
// re-fetch an instruction. A taken branch flushes and redirects in one cycle.
// Optional feature: define IF_ALE_EN to flag misaligned fetch addresses.
import if_pkg::*;

module if_fetch_buf #(
    parameter int              PC_W      = 32,
    parameter int              BUF_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(IF_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_excp,
    output logic            inst_sram_en,
    output logic [3:0]      inst_sram_we,
    output logic [PC_W-1:0] inst_sram_addr,
    output logic [31:0]     inst_sram_wdata,
    input  logic [31:0]     inst_sram_rdata
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] issued_pc;
    logic [PC_W-1:0] fetch_addr;
    logic            inflight;
    logic            kill;
    logic            issue;
    logic            fire;
    logic            push;
    logic            has_entry;
    logic            has_credit;
    logic            fetch_excp;
    logic            issued_excp;
    logic [CW-1:0]   count;
    logic [CW:0]     used;
    logic [CW:0]     avail;
    if_entry_t       head;
    if_entry_t       push_entry;

    // Output handshake; a redirect hides the (about to be flushed) head.
    assign has_entry = (count != '0);
    assign out_valid = ~reset & ~br_taken & has_entry;
    assign fire      = out_valid & out_ready;

    // Credit: free slots minus the read already in flight, plus the slot freed by this cycle's pop.
    assign used       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign avail      = (CW + 1)'(BUF_DEPTH) + {{CW{1'b0}}, fire};
    assign has_credit = used < avail;

    assign fetch_addr = (br_taken & ~reset) ? br_target : pc;

`ifdef IF_ALE_EN
    logic ale_stop;

    // A misaligned fetch still consumes a slot but never reaches the SRAM.
    assign fetch_excp   = (fetch_addr[1:0] != 2'b00);
    assign issue        = ~reset & (br_taken | (has_credit & ~ale_stop));
    assign inst_sram_en = issue & ~fetch_excp;

    // After a misaligned fetch, stay quiet until the next redirect picks a new address.
    always_ff @(posedge clk) begin
        if (reset) begin
            ale_stop <= 1'b0;
        end else if (issue) begin
            ale_stop <= fetch_excp;
        end
    end
`else
    assign fetch_excp   = 1'b0;
    assign issue        = ~reset & (br_taken | has_credit);
    assign inst_sram_en = issue;
`endif

    assign inst_sram_addr  = fetch_addr;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    // PC and in-flight bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= issue;
            // The redirect's own read always issues, so the response after it belongs
            // to the target; kill only guards a redirect that could not issue a read.
            kill     <= br_taken & inflight & ~issue;
            if (br_taken) begin
                pc <= br_target + PC_W'(4);
            end else if (issue) begin
                pc <= pc + PC_W'(4);
            end
        end
    end

    // Remember what was issued so the response can be tagged; qualified by inflight.
    always_ff @(posedge clk) begin
        if (issue) begin
            issued_pc   <= fetch_addr;
            issued_excp <= fetch_excp;
        end
    end

    // Response capture: a redirect or kill this cycle discards the returning word.
    assign push = inflight & ~kill & ~br_taken;

    // Build the entry to push; a faulting fetch carries no instruction bits.
    // NOTE: every field gets a default first so the block never infers a latch.
    always_comb begin
        push_entry      = '0;
        push_entry.excp = issued_excp;
        push_entry.pc   = IF_PC_W'(issued_pc);
        if (!issued_excp) begin
            push_entry.inst = inst_sram_rdata;
        end
    end

    if_fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (fire),
        .flush (br_taken),
        .wdata (push_entry),
        .rdata (head),
        .count (count)
    );

    assign out_pc   = head.pc[PC_W-1:0];
    assign out_inst = has_entry ? head.inst : INST_NOP;
    // The excp bit is only ever stored as 1 when IF_ALE_EN is defined.
    assign out_excp = has_entry & head.excp;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Directed bench for if_fetch_buf: sequential fetch, stall, redirects,
// mid-stream reset and (with IF_ALE_EN) the misaligned-fetch path.
`timescale 1ns/1ps

module tb_if_fetch_buf;

    localparam logic [31:0] B = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_taken;
    logic [31:0] br_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_excp;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_buf #(
        .PC_W      (32),
        .BUF_DEPTH (2),
        .RESET_PC  (32'h1c00_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_excp        (out_excp),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    // Synchronous SRAM: data valid one cycle after the request.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= sram_word(inst_sram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, drive inputs just after the edge, then settle before checking.
    task automatic step(input logic rst, input logic rdy, input logic br, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset     = rst;
        out_ready = rdy;
        br_taken  = br;
        br_target = tgt;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc_exp);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_pc"}, out_pc, pc_exp);
        chk({tag, "_inst"}, out_inst, sram_word(pc_exp));
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;

        // Reset behaviour.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_en", {31'b0, inst_sram_en}, 32'd0);
        chk("rst_addr", inst_sram_addr, B);
        chk("rst_we", {28'b0, inst_sram_we}, 32'd0);
        chk("rst_wdata", inst_sram_wdata, 32'd0);

        // Sequential fetch, out_ready held high.
        step(0, 1, 0, 0);                                   // c0
        chk("c0_en", {31'b0, inst_sram_en}, 32'd1);
        chk("c0_addr", inst_sram_addr, B);
        chk("c0_valid", {31'b0, out_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // c1
        chk("c1_addr", inst_sram_addr, B + 32'h4);
        chk("c1_valid", {31'b0, out_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // c2
        chk_head("c2", B);
        chk("c2_excp", {31'b0, out_excp}, 32'd0);
        chk("c2_addr", inst_sram_addr, B + 32'h8);
        step(0, 1, 0, 0);                                   // c3
        chk_head("c3", B + 32'h4);
        step(0, 1, 0, 0);                                   // c4
        chk_head("c4", B + 32'h8);
        chk("c4_addr", inst_sram_addr, B + 32'h10);

        // Five-cycle decode stall.
        step(0, 0, 0, 0);                                   // c5
        chk_head("c5", B + 32'hc);
        chk("c5_en", {31'b0, inst_sram_en}, 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);       // c6..c8
        step(0, 0, 0, 0);                                   // c9
        chk_head("c9", B + 32'hc);
        chk("c9_en", {31'b0, inst_sram_en}, 32'd0);
        chk("c9_addr_hold", inst_sram_addr, B + 32'h14);

        // Release: full FIFO with fire may issue; pcs resume in order.
        step(0, 1, 0, 0);                                   // c10
        chk_head("c10", B + 32'hc);
        chk("c10_en", {31'b0, inst_sram_en}, 32'd1);
        chk("c10_addr", inst_sram_addr, B + 32'h14);
        step(0, 1, 0, 0);                                   // c11
        chk_head("c11", B + 32'h10);
        step(0, 1, 0, 0);                                   // c12
        chk_head("c12", B + 32'h14);
        step(0, 1, 0, 0);                                   // c13
        chk_head("c13", B + 32'h18);

        // Redirect with a buffered entry and a response arriving.
        step(0, 0, 1, B + 32'h100);                         // c14
        chk("br_valid", {31'b0, out_valid}, 32'd0);
        chk("br_en", {31'b0, inst_sram_en}, 32'd1);
        chk("br_addr", inst_sram_addr, B + 32'h100);
        step(0, 1, 0, 0);                                   // c15
        chk("br1_valid", {31'b0, out_valid}, 32'd0);
        chk("br1_addr", inst_sram_addr, B + 32'h104);
        step(0, 1, 0, 0);                                   // c16
        chk_head("br2", B + 32'h100);
        step(0, 1, 0, 0);                                   // c17
        chk_head("br3", B + 32'h104);

        // Back-to-back redirects: the newest target wins.
        step(0, 1, 1, B + 32'h200);                         // c18
        chk("bb0_valid", {31'b0, out_valid}, 32'd0);
        chk("bb0_addr", inst_sram_addr, B + 32'h200);
        step(0, 1, 1, B + 32'h300);                         // c19
        chk("bb1_valid", {31'b0, out_valid}, 32'd0);
        chk("bb1_addr", inst_sram_addr, B + 32'h300);
        step(0, 1, 0, 0);                                   // c20
        chk("bb2_valid", {31'b0, out_valid}, 32'd0);
        chk("bb2_addr", inst_sram_addr, B + 32'h304);
        step(0, 1, 0, 0);                                   // c21
        chk_head("bb3", B + 32'h300);
        step(0, 1, 0, 0);                                   // c22
        chk_head("bb4", B + 32'h304);

        // Fill the buffer, then reset mid-stream.
        step(0, 0, 0, 0);                                   // c23
        chk_head("fill0", B + 32'h308);
        step(0, 0, 0, 0);                                   // c24
        chk_head("fill1", B + 32'h308);
        step(1, 0, 0, 0);                                   // c25
        chk("mrst0_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst0_en", {31'b0, inst_sram_en}, 32'd0);
        step(1, 0, 0, 0);                                   // c26
        chk("mrst1_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst1_addr", inst_sram_addr, B);
        step(0, 1, 0, 0);                                   // c27
        chk("rs0_en", {31'b0, inst_sram_en}, 32'd1);
        chk("rs0_addr", inst_sram_addr, B);
        chk("rs0_valid", {31'b0, out_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // c28
        chk("rs1_valid", {31'b0, out_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // c29
        chk_head("rs2", B);

`ifdef IF_ALE_EN
        // Misaligned redirect target: one faulting entry, then a stall until redirected.
        step(0, 1, 1, B + 32'h102);                         // c30
        chk("ale0_en", {31'b0, inst_sram_en}, 32'd0);
        chk("ale0_valid", {31'b0, out_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // c31
        chk("ale1_en", {31'b0, inst_sram_en}, 32'd0);
        chk("ale1_valid", {31'b0, out_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // c32
        chk("ale2_valid", {31'b0, out_valid}, 32'd1);
        chk("ale2_pc", out_pc, B + 32'h102);
        chk("ale2_excp", {31'b0, out_excp}, 32'd1);
        chk("ale2_inst", out_inst, 32'd0);
        chk("ale2_en", {31'b0, inst_sram_en}, 32'd0);
        step(0, 1, 0, 0);                                   // c33
        chk("ale3_valid", {31'b0, out_valid}, 32'd0);
        chk("ale3_en", {31'b0, inst_sram_en}, 32'd0);
        step(0, 1, 1, B + 32'h400);                         // c34
        chk("ale4_en", {31'b0, inst_sram_en}, 32'd1);
        chk("ale4_addr", inst_sram_addr, B + 32'h400);
        step(0, 1, 0, 0);                                   // c35
        step(0, 1, 0, 0);                                   // c36
        chk_head("ale6", B + 32'h400);
        chk("ale6_excp", {31'b0, out_excp}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
